// File: rtl/hazard_pkg.sv
// Shared types, exception codes and redirect vectors for the hazard controller.
package hazard_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned CODE_W  = 5;
    localparam int unsigned DRAIN_W = 3;

    // Exception codes as reported by the exception stage
    localparam logic [CODE_W-1:0] EXC_INT  = 5'h00;
    localparam logic [CODE_W-1:0] EXC_SYS  = 5'h08;
    localparam logic [CODE_W-1:0] EXC_BRK  = 5'h09;
    localparam logic [CODE_W-1:0] EXC_RI   = 5'h0a;
    localparam logic [CODE_W-1:0] EXC_OV   = 5'h0c;
    localparam logic [CODE_W-1:0] EXC_TRAP = 5'h0d;
    localparam logic [CODE_W-1:0] EXC_ERET = 5'h0e;

    localparam logic [XLEN-1:0] INT_VEC_DEF = 32'h0000_0020;
    localparam logic [XLEN-1:0] EXC_VEC_DEF = 32'h0000_0040;

    typedef enum logic [1:0] {
        HZ_IDLE     = 2'd0,
        HZ_REDIRECT = 2'd1,
        HZ_DRAIN    = 2'd2
    } hz_state_e;

    // Redirect target for a given exception code; unknown codes go to the general vector
    function automatic logic [XLEN-1:0] exc_target(
        input logic [CODE_W-1:0] code,
        input logic [XLEN-1:0]   epc,
        input logic [XLEN-1:0]   int_vec,
        input logic [XLEN-1:0]   exc_vec
    );
        logic [XLEN-1:0] tgt;
        case (code)
            EXC_INT:                                   tgt = int_vec;
            EXC_SYS, EXC_BRK, EXC_RI, EXC_OV, EXC_TRAP: tgt = exc_vec;
            EXC_ERET:                                  tgt = epc;
            default:                                   tgt = exc_vec;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between ID sources and in-flight loads.
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int unsigned LOAD_DEPTH = 1
) (
    input  logic [LOAD_DEPTH-1:0]       ld_valid_i,
    input  logic [LOAD_DEPTH*REG_W-1:0] ld_wd_i,
    input  logic [REG_W-1:0]            id_rs_i,
    input  logic [REG_W-1:0]            id_rt_i,
    input  logic                        id_reg1_read_i,
    input  logic                        id_reg2_read_i,
    output logic                        lu_c_o
);

    logic [REG_W-1:0] wd;

    // Any load whose non-zero destination matches a register ID actually reads
    always_comb begin
        lu_c_o = 1'b0;
        wd     = '0;
        for (int j = 0; j < int'(LOAD_DEPTH); j++) begin
            wd = ld_wd_i[j*REG_W +: REG_W];
            if (ld_valid_i[j] && (wd != '0) &&
                (((wd == id_rs_i) && id_reg1_read_i) ||
                 ((wd == id_rt_i) && id_reg2_read_i))) begin
                lu_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller: merges stall requests, takes exceptions, drives PC redirect.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned     NUM_STAGES = 5,
    parameter int unsigned     LOAD_DEPTH = 1,
    parameter int unsigned     EXC_STAGE  = 3,
    parameter int unsigned     FLUSH_CYC  = 1,
    parameter logic [XLEN-1:0] INT_VEC    = INT_VEC_DEF,
    parameter logic [XLEN-1:0] EXC_VEC    = EXC_VEC_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_STAGES-1:0]       req_stall_i,
    input  logic [LOAD_DEPTH-1:0]       ld_valid_i,
    input  logic [LOAD_DEPTH*REG_W-1:0] ld_wd_i,
    input  logic [REG_W-1:0]            id_rs_i,
    input  logic [REG_W-1:0]            id_rt_i,
    input  logic                        id_reg1_read_i,
    input  logic                        id_reg2_read_i,
    input  logic                        exc_valid_i,
    input  logic [CODE_W-1:0]           exc_code_i,
    input  logic [XLEN-1:0]             cp0_epc_i,
    output logic [NUM_STAGES-1:0]       stall_o,
    output logic [NUM_STAGES-1:0]       flush_o,
    output logic                        redirect_o,
    output logic [XLEN-1:0]             redirect_pc_o,
    output logic [XLEN-1:0]             stall_cnt_o,
    output logic [XLEN-1:0]             flush_cnt_o
);

    // Stages 0..EXC_STAGE are squashed when an exception is taken
    localparam logic [NUM_STAGES-1:0] EXC_MASK =
        NUM_STAGES'((64'd1 << (EXC_STAGE + 1)) - 64'd1);

    logic                  lu;
    logic [NUM_STAGES-1:0] eff_req;
    logic [NUM_STAGES-1:0] stall_base;
    logic [NUM_STAGES-1:0] flush_base;
    logic                  any_req;
    logic                  take;
    logic [XLEN-1:0]       target;

    hz_state_e             state_q, state_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  redirect_q;
    logic [XLEN-1:0]       redirect_pc_q;
    logic [XLEN-1:0]       stall_cnt_q;
    logic [XLEN-1:0]       flush_cnt_q;

    load_use_detect #(
        .LOAD_DEPTH (LOAD_DEPTH)
    ) u_load_use_detect (
        .ld_valid_i     (ld_valid_i),
        .ld_wd_i        (ld_wd_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg2_read_i (id_reg2_read_i),
        .lu_c_o         (lu)
    );

    // Effective per-stage request: load-use stalls ID
    always_comb begin
        eff_req    = req_stall_i;
        eff_req[1] = req_stall_i[1] | lu;
    end

    // Stall everything at or before the oldest requester, bubble the stage just after it
    always_comb begin
        stall_base = '0;
        flush_base = '0;
        any_req    = 1'b0;
        for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
            any_req       = any_req | eff_req[k];
            stall_base[k] = any_req;
        end
        for (int k = 1; k < int'(NUM_STAGES); k++) begin
            flush_base[k] = stall_base[k-1] & ~stall_base[k];
        end
    end

    assign take   = exc_valid_i & ~stall_base[EXC_STAGE] & (state_q == HZ_IDLE);
    assign target = exc_target(exc_code_i, cp0_epc_i, INT_VEC, EXC_VEC);

    // Final stall/flush: an exception squashes and overrides stalls; redirect keeps IF flushed
    always_comb begin
        stall_o = stall_base;
        flush_o = flush_base;
        if (take) begin
            stall_o = '0;
            flush_o = EXC_MASK;
        end
        if (state_q != HZ_IDLE) begin
            flush_o[0] = 1'b1;
        end
    end

    // Redirect sequencer next state
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            HZ_IDLE: begin
                if (take) begin
                    state_d = HZ_REDIRECT;
                end
            end
            HZ_REDIRECT: begin
                if (FLUSH_CYC > 0) begin
                    state_d = HZ_DRAIN;
                    drain_d = DRAIN_W'(FLUSH_CYC - 1);
                end else begin
                    state_d = HZ_IDLE;
                end
            end
            HZ_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = HZ_IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            default: state_d = HZ_IDLE;
        endcase
    end

    // Sequencer state, redirect strobe/target and saturating event counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= HZ_IDLE;
            drain_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            redirect_q <= take;
            if (take) begin
                redirect_pc_q <= target;
            end
            if ((|stall_o) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + XLEN'(1);
            end
            if (take && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + XLEN'(1);
            end
        end
    end

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int N   = 5;
    localparam int LD  = 1;
    localparam int EXC = 3;
    localparam int FC  = 1;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_stall;
    logic [LD-1:0] ld_valid;
    logic [LD*5-1:0] ld_wd;
    logic [4:0]    id_rs, id_rt;
    logic          rd1, rd2;
    logic          exc_valid;
    logic [4:0]    exc_code;
    logic [31:0]   epc;
    logic [N-1:0]  stall_o, flush_o;
    logic          redirect_o;
    logic [31:0]   redirect_pc_o, stall_cnt_o, flush_cnt_o;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          busy_left;
    logic        redir_exp;
    logic [31:0] pc_exp, scnt_exp, fcnt_exp;

    pipeline_hazard_ctrl #(
        .NUM_STAGES (N),
        .LOAD_DEPTH (LD),
        .EXC_STAGE  (EXC),
        .FLUSH_CYC  (FC),
        .INT_VEC    (32'h20),
        .EXC_VEC    (32'h40)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_stall_i    (req_stall),
        .ld_valid_i     (ld_valid),
        .ld_wd_i        (ld_wd),
        .id_rs_i        (id_rs),
        .id_rt_i        (id_rt),
        .id_reg1_read_i (rd1),
        .id_reg2_read_i (rd2),
        .exc_valid_i    (exc_valid),
        .exc_code_i     (exc_code),
        .cp0_epc_i      (epc),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy_left = 0;
        redir_exp = 1'b0;
        pc_exp    = '0;
        scnt_exp  = '0;
        fcnt_exp  = '0;
    endtask

    task automatic clear_inputs();
        req_stall = '0; ld_valid = '0; ld_wd = '0;
        id_rs = '0; id_rt = '0; rd1 = 1'b0; rd2 = 1'b0;
        exc_valid = 1'b0; exc_code = '0; epc = '0;
    endtask

    // One clock: predict from the rules, check at negedge, advance model at posedge
    task automatic cycle();
        logic         lu;
        logic [4:0]   wd;
        int           h;
        logic         take;
        logic [N-1:0] es, ef, req;
        logic [31:0]  tgt;
        lu = 1'b0;
        for (int j = 0; j < LD; j++) begin
            wd = ld_wd[j*5 +: 5];
            if (ld_valid[j] && wd != 0 && ((wd == id_rs && rd1) || (wd == id_rt && rd2)))
                lu = 1'b1;
        end
        req = req_stall;
        if (lu) req[1] = 1'b1;
        h = -1;
        for (int k = 0; k < N; k++) if (req[k]) h = k;
        for (int k = 0; k < N; k++) begin
            es[k] = (k <= h);
            ef[k] = (h >= 0) && (k == h + 1);
        end
        take = exc_valid && !es[EXC] && (busy_left == 0);
        if (take) begin
            es = '0;
            for (int k = 0; k < N; k++) ef[k] = (k <= EXC);
        end
        if (busy_left > 0) ef[0] = 1'b1;
        if (exc_code == 5'h00)      tgt = 32'h20;
        else if (exc_code == 5'h0e) tgt = epc;
        else                        tgt = 32'h40;

        @(negedge clk);
        check("stall_o", 32'(stall_o), 32'(es));
        check("flush_o", 32'(flush_o), 32'(ef));
        check("redirect_o", 32'(redirect_o), 32'(redir_exp));
        check("redirect_pc_o", redirect_pc_o, pc_exp);
        check("stall_cnt_o", stall_cnt_o, scnt_exp);
        check("flush_cnt_o", flush_cnt_o, fcnt_exp);

        @(posedge clk);
        if (es != 0 && scnt_exp != 32'hFFFF_FFFF) scnt_exp++;
        if (take) begin
            if (fcnt_exp != 32'hFFFF_FFFF) fcnt_exp++;
            pc_exp    = tgt;
            redir_exp = 1'b1;
            busy_left = 1 + FC;
        end else begin
            redir_exp = 1'b0;
            if (busy_left > 0) busy_left--;
        end
        #1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [4:0] codes [9];
        codes = '{5'h00, 5'h08, 5'h09, 5'h0a, 5'h0c, 5'h0d, 5'h0e, 5'h05, 5'h1f};
        clear_inputs();
        model_reset();
        rst_n = 1'b0;
        #12;
        check("rst stall_o", 32'(stall_o), 32'h0);
        check("rst flush_o", 32'(flush_o), 32'h0);
        check("rst redirect_o", 32'(redirect_o), 32'h0);
        check("rst redirect_pc_o", redirect_pc_o, 32'h0);
        check("rst stall_cnt_o", stall_cnt_o, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // divider busy in stage 2 for three cycles
        req_stall = 5'b00100;
        repeat (3) cycle();
        check("div stall_cnt", stall_cnt_o, 32'd3);
        idle(1);

        // load-use on rs, then the same with r0 destination
        ld_valid = 1'b1; ld_wd = 5'd5; id_rs = 5'd5; rd1 = 1'b1;
        @(negedge clk);
        check("lu stall_o", 32'(stall_o), 32'h03);
        check("lu flush_o", 32'(flush_o), 32'h04);
        @(posedge clk); #1;
        scnt_exp++;
        cycle();
        ld_wd = 5'd0; id_rs = 5'd0;
        cycle();
        ld_wd = 5'd7; id_rt = 5'd7; rd2 = 1'b1; rd1 = 1'b0;
        cycle();
        idle(1);

        // syscall
        exc_valid = 1'b1; exc_code = 5'h08;
        @(negedge clk);
        check("sys flush_o T", 32'(flush_o), 32'h0F);
        @(posedge clk); #1;
        exc_valid = 1'b0;
        fcnt_exp = 1; pc_exp = 32'h40; redir_exp = 1'b1; busy_left = 1 + FC;
        check("sys redirect_pc", redirect_pc_o, 32'h40);
        check("sys flush_cnt", flush_cnt_o, 32'd1);
        idle(4);

        // ERET then interrupt
        exc_valid = 1'b1; exc_code = 5'h0e; epc = 32'hBFC0_0100;
        cycle();
        check("eret redirect_pc", redirect_pc_o, 32'hBFC0_0100);
        idle(3);
        exc_valid = 1'b1; exc_code = 5'h00;
        cycle();
        check("int redirect_pc", redirect_pc_o, 32'h20);
        idle(3);

        // exception held behind a stage-4 stall, then taken
        exc_valid = 1'b1; exc_code = 5'h0c; req_stall = 5'b10000;
        repeat (2) cycle();
        req_stall = '0;
        cycle();
        check("held take redirect", 32'(redirect_o), 32'h1);
        idle(3);

        // exception and a stage-2 stall together: flush wins
        exc_valid = 1'b1; exc_code = 5'h09; req_stall = 5'b00100;
        @(negedge clk);
        check("exc+stall stall_o", 32'(stall_o), 32'h0);
        check("exc+stall flush_o", 32'(flush_o), 32'h0F);
        @(posedge clk); #1;
        clear_inputs();
        if (fcnt_exp != 32'hFFFF_FFFF) fcnt_exp++;
        pc_exp = 32'h40; redir_exp = 1'b1; busy_left = 1 + FC;

        // reset in the middle of the redirect
        rst_n = 1'b0;
        #1;
        check("midrst redirect_o", 32'(redirect_o), 32'h0);
        check("midrst stall_cnt", stall_cnt_o, 32'h0);
        check("midrst flush_cnt", flush_cnt_o, 32'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        idle(3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) req_stall[k] = ($urandom_range(0, 9) == 0);
            ld_valid  = LD'($urandom_range(0, 1));
            ld_wd     = 5'($urandom_range(0, 3));
            id_rs     = 5'($urandom_range(0, 3));
            id_rt     = 5'($urandom_range(0, 3));
            rd1       = 1'($urandom_range(0, 1));
            rd2       = 1'($urandom_range(0, 1));
            exc_valid = ($urandom_range(0, 5) == 0);
            exc_code  = codes[$urandom_range(0, 8)];
            epc       = $urandom;
            cycle();
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
